// File: rtl/m_ice40sim_wbsram.sv
// Wishbone-classic SRAM model for iCE40 simulation builds: configurable width,
// depth and wait states, byte lanes, error termination, cycle abort and access counters.
//
// state | meaning
// IDLE  | waiting for CYC_I & STB_I (blocked while a termination is still showing)
// WAIT  | counting down wait states on the latched request
// TERM  | termination edge: ACK/ERR, read data and counters register on leaving
module m_ice40sim_wbsram #(
    parameter int    SRAMADRWIDTH = 17,
    parameter int    DWIDTH       = 32,
    parameter int    MEMDEPTH     = 131072,
    parameter int    WAITSTATES   = 1,
    parameter string INITFILE     = ""
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    input  logic                    CYC_I,
    input  logic                    STB_I,
    input  logic                    WE_I,
    input  logic [DWIDTH/8-1:0]     SEL_I,
    input  logic [SRAMADRWIDTH-1:0] ADR_I,
    input  logic [DWIDTH-1:0]       DAT_I,
    output logic [DWIDTH-1:0]       DAT_O,
    output logic                    ACK_O,
    output logic                    ERR_O,
    output logic [31:0]             RDCNT,
    output logic [31:0]             WRCNT
);

    localparam int NSEL = DWIDTH / 8;
    localparam int MAW  = (MEMDEPTH > 1) ? $clog2(MEMDEPTH) : 1;
    localparam logic [SRAMADRWIDTH:0] DEPTH_LIM = (SRAMADRWIDTH + 1)'(MEMDEPTH);
    localparam logic [3:0] WS = 4'(WAITSTATES);

    typedef enum logic [1:0] {IDLE, WAIT, TERM} state_t;

    state_t                  state, state_nxt;
    logic [3:0]              cnt_q, cnt_nxt;
    logic [SRAMADRWIDTH-1:0] adr_q, cur_adr;
    logic                    we_q, cur_we;
    logic [NSEL-1:0]         sel_q, cur_sel;
    logic [DWIDTH-1:0]       dat_q, cur_dat;
    logic                    ack_q, err_q;
    logic                    accept, commit, cur_hit, lat_hit;
    logic [DWIDTH-1:0]       dat_o_q;
    logic [31:0]             rdcnt_q, wrcnt_q;
    logic [DWIDTH-1:0]       mem [MEMDEPTH];

    // With zero wait states the commit happens on the accepting edge, so the
    // request is taken straight from the bus instead of the latches.
    always_comb begin
        cur_adr = (state == IDLE) ? ADR_I : adr_q;
        cur_we  = (state == IDLE) ? WE_I  : we_q;
        cur_sel = (state == IDLE) ? SEL_I : sel_q;
        cur_dat = (state == IDLE) ? DAT_I : dat_q;
        cur_hit = {1'b0, cur_adr} < DEPTH_LIM;
        lat_hit = {1'b0, adr_q} < DEPTH_LIM;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                accept = CYC_I && STB_I && !ack_q && !err_q;
                if (accept) begin
                    cnt_nxt   = WS;
                    state_nxt = (WAITSTATES == 0) ? TERM : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt_q - 4'd1;
                if (!CYC_I)           state_nxt = IDLE;
                else if (cnt_q == 4'd1) state_nxt = TERM;
            end
            TERM:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        commit = (state_nxt == TERM) && (state != TERM) && cur_we && cur_hit;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state   <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_o_q <= '0;
            rdcnt_q <= '0;
            wrcnt_q <= '0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (accept) begin
                adr_q <= ADR_I;
                we_q  <= WE_I;
                sel_q <= SEL_I;
                dat_q <= DAT_I;
            end
            if (state == TERM && CYC_I) begin
                if (lat_hit) begin
                    ack_q <= 1'b1;
                    if (we_q) begin
                        wrcnt_q <= wrcnt_q + 32'd1;
                    end else begin
                        rdcnt_q <= rdcnt_q + 32'd1;
                        dat_o_q <= mem[adr_q[MAW-1:0]];
                    end
                end else begin
                    err_q   <= 1'b1;
                    dat_o_q <= '0;
                end
            end
        end
    end

    // Memory is deliberately outside the reset domain; reset only blocks a pending commit.
    always_ff @(posedge CLK_I) begin
        if (commit && !RST_I) begin
            for (int i = 0; i < NSEL; i++) begin
                if (cur_sel[i]) mem[cur_adr[MAW-1:0]][8*i +: 8] <= cur_dat[8*i +: 8];
            end
        end
    end

    // A dropped CYC_I in the termination cycle hides the strobe from the master.
    assign ACK_O = ack_q & CYC_I;
    assign ERR_O = err_q & CYC_I;
    assign DAT_O = dat_o_q;
    assign RDCNT = rdcnt_q;
    assign WRCNT = wrcnt_q;

endmodule

// File: tb/tb_m_ice40sim_wbsram.sv
// Directed bench for m_ice40sim_wbsram: several instances cover the wait-state,
// width and depth variants; each task checks one feature against hand-derived values.
module tb_m_ice40sim_wbsram;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  cyc;
    logic        stb, we;
    logic [3:0]  sel;
    logic [16:0] adr;
    logic [31:0] dat_i;
    logic [4:0]  ack, err;
    logic [31:0] dat32 [4];
    logic [15:0] dat16;
    logic [31:0] rdcnt [5];
    logic [31:0] wrcnt [5];
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    m_ice40sim_wbsram #(.WAITSTATES(0), .MEMDEPTH(1024)) u0 (
        .CLK_I(clk), .RST_I(rst), .CYC_I(cyc[0]), .STB_I(stb), .WE_I(we), .SEL_I(sel),
        .ADR_I(adr), .DAT_I(dat_i), .DAT_O(dat32[0]), .ACK_O(ack[0]), .ERR_O(err[0]),
        .RDCNT(rdcnt[0]), .WRCNT(wrcnt[0]));

    m_ice40sim_wbsram u1 (
        .CLK_I(clk), .RST_I(rst), .CYC_I(cyc[1]), .STB_I(stb), .WE_I(we), .SEL_I(sel),
        .ADR_I(adr), .DAT_I(dat_i), .DAT_O(dat32[1]), .ACK_O(ack[1]), .ERR_O(err[1]),
        .RDCNT(rdcnt[1]), .WRCNT(wrcnt[1]));

    m_ice40sim_wbsram #(.WAITSTATES(3), .MEMDEPTH(1024)) u3 (
        .CLK_I(clk), .RST_I(rst), .CYC_I(cyc[2]), .STB_I(stb), .WE_I(we), .SEL_I(sel),
        .ADR_I(adr), .DAT_I(dat_i), .DAT_O(dat32[2]), .ACK_O(ack[2]), .ERR_O(err[2]),
        .RDCNT(rdcnt[2]), .WRCNT(wrcnt[2]));

    m_ice40sim_wbsram #(.WAITSTATES(4), .MEMDEPTH(1024)) u4 (
        .CLK_I(clk), .RST_I(rst), .CYC_I(cyc[3]), .STB_I(stb), .WE_I(we), .SEL_I(sel),
        .ADR_I(adr), .DAT_I(dat_i), .DAT_O(dat32[3]), .ACK_O(ack[3]), .ERR_O(err[3]),
        .RDCNT(rdcnt[3]), .WRCNT(wrcnt[3]));

    m_ice40sim_wbsram #(.DWIDTH(16), .WAITSTATES(1), .MEMDEPTH(1024)) u16 (
        .CLK_I(clk), .RST_I(rst), .CYC_I(cyc[4]), .STB_I(stb), .WE_I(we), .SEL_I(sel[1:0]),
        .ADR_I(adr), .DAT_I(dat_i[15:0]), .DAT_O(dat16), .ACK_O(ack[4]), .ERR_O(err[4]),
        .RDCNT(rdcnt[4]), .WRCNT(wrcnt[4]));

    function automatic logic [31:0] rd_dat(input int k);
        if (k == 4) return {16'h0, dat16};
        return dat32[k];
    endfunction

    // One complete transfer; lat counts edges after the accepting edge until ACK/ERR.
    task automatic xfer(input int k, input logic w, input logic [3:0] s, input logic [16:0] a,
                        input logic [31:0] d, output int lat, output logic av, output logic ev,
                        output logic [31:0] rdata, output logic extra);
        @(posedge clk); #1;
        cyc[k] = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat_i = d;
        @(posedge clk); #1;
        stb = 1'b0;
        lat = -1; av = 1'b0; ev = 1'b0; rdata = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (ack[k] | err[k]) begin
                lat = n; av = ack[k]; ev = err[k]; rdata = rd_dat(k);
                break;
            end
        end
        @(posedge clk); #1;
        extra = ack[k] | err[k];
        cyc[k] = 1'b0;
    endtask

    task automatic test_reset();
        int lat; logic av, ev, ex; logic [31:0] rd;
        total++; if (ack[0] !== 1'b0 || err[0] !== 1'b0) $display("FAIL reset_ack_err: ack=%b err=%b want 0 0", ack[0], err[0]); else passed++;
        total++; if (dat32[0] !== 32'h0) $display("FAIL reset_dat: got %h want 00000000", dat32[0]); else passed++;
        total++; if (rdcnt[0] !== 32'h0 || wrcnt[0] !== 32'h0) $display("FAIL reset_cnt: rd=%0d wr=%0d want 0 0", rdcnt[0], wrcnt[0]); else passed++;
        rst = 1'b0;
        u1.mem[0] <= 32'h0000_0013;
        xfer(1, 1'b0, 4'hF, 17'h0, 32'h0, lat, av, ev, rd, ex);
        total++; if (rd !== 32'h0000_0013 || av !== 1'b1) $display("FAIL preload_read: got %h ack=%b want 00000013 1", rd, av); else passed++;
    endtask

    task automatic test_latency();
        int ks [3] = '{0, 1, 2};
        int wss [3] = '{0, 1, 3};
        int lat; logic av, ev, ex; logic [31:0] rd;
        for (int i = 0; i < 3; i++) begin
            xfer(ks[i], 1'b1, 4'hF, 17'h10, 32'hDEAD_BEEF, lat, av, ev, rd, ex);
            total++; if (lat != wss[i] + 1 || av !== 1'b1 || ev !== 1'b0) $display("FAIL wr_latency ws=%0d: lat=%0d ack=%b err=%b want %0d 1 0", wss[i], lat, av, ev, wss[i] + 1); else passed++;
            total++; if (ex !== 1'b0) $display("FAIL ack_one_cycle ws=%0d: got %b want 0", wss[i], ex); else passed++;
            xfer(ks[i], 1'b0, 4'hF, 17'h10, 32'h0, lat, av, ev, rd, ex);
            total++; if (rd !== 32'hDEAD_BEEF || lat != wss[i] + 1) $display("FAIL rd_back ws=%0d: got %h lat=%0d want deadbeef %0d", wss[i], rd, lat, wss[i] + 1); else passed++;
            total++; if (rdcnt[ks[i]] !== ((ks[i] == 1) ? 32'd2 : 32'd1) || wrcnt[ks[i]] !== 32'd1) $display("FAIL lat_counts ws=%0d: rd=%0d wr=%0d", wss[i], rdcnt[ks[i]], wrcnt[ks[i]]); else passed++;
        end
    endtask

    task automatic test_byte_lanes();
        int lat; logic av, ev, ex; logic [31:0] rd;
        xfer(1, 1'b1, 4'hF, 17'h20, 32'h1122_3344, lat, av, ev, rd, ex);
        xfer(1, 1'b1, 4'b0101, 17'h20, 32'hAABB_CCDD, lat, av, ev, rd, ex);
        xfer(1, 1'b0, 4'hF, 17'h20, 32'h0, lat, av, ev, rd, ex);
        total++; if (rd !== 32'h11BB_33DD) $display("FAIL lanes32: got %h want 11bb33dd", rd); else passed++;
        xfer(1, 1'b1, 4'b0000, 17'h20, 32'hFFFF_FFFF, lat, av, ev, rd, ex);
        total++; if (av !== 1'b1) $display("FAIL sel0_ack: got %b want 1", av); else passed++;
        xfer(1, 1'b0, 4'hF, 17'h20, 32'h0, lat, av, ev, rd, ex);
        total++; if (rd !== 32'h11BB_33DD || wrcnt[1] !== 32'd4 || rdcnt[1] !== 32'd4) $display("FAIL sel0_nowrite: got %h wr=%0d rd=%0d want 11bb33dd 4 4", rd, wrcnt[1], rdcnt[1]); else passed++;
        xfer(4, 1'b1, 4'b0011, 17'h20, 32'h0000_1122, lat, av, ev, rd, ex);
        xfer(4, 1'b1, 4'b0010, 17'h20, 32'h0000_AABB, lat, av, ev, rd, ex);
        xfer(4, 1'b0, 4'b0011, 17'h20, 32'h0, lat, av, ev, rd, ex);
        total++; if (rd !== 32'h0000_AA22) $display("FAIL lanes16: got %h want 0000aa22", rd); else passed++;
    endtask

    task automatic test_error();
        int lat; logic av, ev, ex; logic [31:0] rd;
        xfer(0, 1'b1, 4'hF, 17'h400, 32'h1234_5678, lat, av, ev, rd, ex);
        total++; if (ev !== 1'b1 || av !== 1'b0 || lat != 1 || ex !== 1'b0) $display("FAIL err_write: err=%b ack=%b lat=%0d extra=%b want 1 0 1 0", ev, av, lat, ex); else passed++;
        total++; if (wrcnt[0] !== 32'd1) $display("FAIL err_wrcnt: got %0d want 1", wrcnt[0]); else passed++;
        xfer(0, 1'b0, 4'hF, 17'h400, 32'h0, lat, av, ev, rd, ex);
        total++; if (ev !== 1'b1 || rd !== 32'h0 || rdcnt[0] !== 32'd1) $display("FAIL err_read: err=%b dat=%h rd=%0d want 1 00000000 1", ev, rd, rdcnt[0]); else passed++;
        xfer(0, 1'b1, 4'hF, 17'h3FF, 32'hCAFE_F00D, lat, av, ev, rd, ex);
        total++; if (av !== 1'b1 || ev !== 1'b0) $display("FAIL last_word_ack: ack=%b err=%b want 1 0", av, ev); else passed++;
        xfer(0, 1'b0, 4'hF, 17'h3FF, 32'h0, lat, av, ev, rd, ex);
        total++; if (rd !== 32'hCAFE_F00D || rdcnt[0] !== 32'd2 || wrcnt[0] !== 32'd2) $display("FAIL last_word_read: got %h rd=%0d wr=%0d", rd, rdcnt[0], wrcnt[0]); else passed++;
    endtask

    task automatic test_abort();
        int lat, spurious; logic av, ev, ex; logic [31:0] rd;
        xfer(2, 1'b1, 4'hF, 17'h30, 32'h1234_5678, lat, av, ev, rd, ex);
        @(posedge clk); #1;
        cyc[2] = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 17'h30; dat_i = 32'h0000_0055;
        @(posedge clk); #1;
        stb = 1'b0;
        @(posedge clk); #1;
        cyc[2] = 1'b0;
        @(posedge clk); #1;
        cyc[2] = 1'b1;
        spurious = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (ack[2] | err[2]) spurious++;
        end
        cyc[2] = 1'b0;
        total++; if (spurious != 0 || wrcnt[2] !== 32'd2) $display("FAIL abort_silent: terms=%0d wr=%0d want 0 2", spurious, wrcnt[2]); else passed++;
        xfer(2, 1'b0, 4'hF, 17'h30, 32'h0, lat, av, ev, rd, ex);
        total++; if (rd !== 32'h1234_5678 || lat != 4 || rdcnt[2] !== 32'd2) $display("FAIL abort_mem: got %h lat=%0d rd=%0d want 12345678 4 2", rd, lat, rdcnt[2]); else passed++;
    endtask

    task automatic test_reset_midread();
        int lat, spurious; logic av, ev, ex; logic [31:0] rd;
        xfer(3, 1'b1, 4'hF, 17'h40, 32'h5A5A_A5A5, lat, av, ev, rd, ex);
        xfer(3, 1'b0, 4'hF, 17'h40, 32'h0, lat, av, ev, rd, ex);
        total++; if (rd !== 32'h5A5A_A5A5 || lat != 5) $display("FAIL ws4_read: got %h lat=%0d want 5a5aa5a5 5", rd, lat); else passed++;
        @(posedge clk); #1;
        cyc[3] = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 17'h40;
        @(posedge clk); #1;
        stb = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        total++; if (dat32[3] !== 32'h0 || rdcnt[3] !== 32'h0 || wrcnt[3] !== 32'h0 || ack[3] !== 1'b0 || err[3] !== 1'b0) $display("FAIL async_reset: dat=%h rd=%0d wr=%0d ack=%b err=%b want all 0", dat32[3], rdcnt[3], wrcnt[3], ack[3], err[3]); else passed++;
        total++; if (rdcnt[0] !== 32'h0) $display("FAIL async_reset_other: got %0d want 0", rdcnt[0]); else passed++;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        spurious = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (ack[3] | err[3]) spurious++;
        end
        cyc[3] = 1'b0;
        total++; if (spurious != 0 || rdcnt[3] !== 32'h0) $display("FAIL reset_abort: terms=%0d rd=%0d want 0 0", spurious, rdcnt[3]); else passed++;
        xfer(3, 1'b0, 4'hF, 17'h40, 32'h0, lat, av, ev, rd, ex);
        total++; if (rd !== 32'h5A5A_A5A5 || rdcnt[3] !== 32'd1) $display("FAIL mem_kept: got %h rd=%0d want 5a5aa5a5 1", rd, rdcnt[3]); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] got;
        @(posedge clk); #1;
        cyc[0] = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 17'h3FF;
        @(posedge clk);
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            got[3 - n] = ack[0];
        end
        cyc[0] = 1'b0; stb = 1'b0;
        total++; if (got !== 4'b1001) $display("FAIL back_to_back: ack pattern %b want 1001", got); else passed++;
        total++; if (rdcnt[0] !== 32'd2 || dat32[0] !== 32'hCAFE_F00D) $display("FAIL b2b_data: rd=%0d dat=%h want 2 cafef00d", rdcnt[0], dat32[0]); else passed++;
    endtask

    task automatic test_wrap();
        int lat; logic av, ev, ex; logic [31:0] rd;
        @(posedge clk); #1;
        u0.rdcnt_q <= 32'hFFFF_FFFF;
        #1;
        xfer(0, 1'b0, 4'hF, 17'h3FF, 32'h0, lat, av, ev, rd, ex);
        total++; if (rdcnt[0] !== 32'h0 || rd !== 32'hCAFE_F00D) $display("FAIL rdcnt_wrap: rd=%h dat=%h want 00000000 cafef00d", rdcnt[0], rd); else passed++;
    endtask

    initial begin
        rst = 1'b1; cyc = '0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat_i = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_latency();
        test_byte_lanes();
        test_error();
        test_abort();
        test_reset_midread();
        test_back_to_back();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
